// File: rtl/chacha_pkg.sv
// ChaCha20 shared definitions.
//   SIGMA          : the four fixed constant words that occupy state words 0..3
//   chacha_state_t : the 16-word working state
//   chacha_fsm_e   : block controller states
//   rotl32         : 32-bit rotate-left
//   pack_state     : state -> 512-bit vector (word i at bits [32*i +: 32])
//   unpack_state   : 512-bit vector -> state (same word ordering)
package chacha_pkg;

    // "expand 32-byte k"; SIGMA[0] is state word 0.
    localparam logic [3:0][31:0] SIGMA = {
        32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865
    };

    typedef logic [31:0] chacha_state_t [16];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_ADD   = 2'd2,
        ST_DONE  = 2'd3
    } chacha_fsm_e;

    function automatic logic [31:0] rotl32(input logic [31:0] v, input int unsigned n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [511:0] pack_state(input chacha_state_t s);
        logic [511:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) begin
            v[32*i +: 32] = s[i];
        end
        return v;
    endfunction

    function automatic void unpack_state(input logic [511:0] v, output chacha_state_t s);
        for (int i = 0; i < 16; i++) begin
            s[i] = v[32*i +: 32];
        end
    endfunction

endpackage

// File: rtl/chacha_half_round.sv
// One ChaCha half-round (column or diagonal), purely combinational.
//   state_i : working state before the half-round
//   diag_i  : 0 = column round, 1 = diagonal round
//   state_o : working state after the half-round
// Quarter round g always takes word g as 'a'; the b/c/d words are
// rotated by 1/2/3 positions within their rows for the diagonal round.
module chacha_half_round
    import chacha_pkg::*;
(
    input  chacha_state_t state_i,
    input  logic          diag_i,
    output chacha_state_t state_o
);

    logic [31:0] ia [4];
    logic [31:0] ib [4];
    logic [31:0] ic [4];
    logic [31:0] id [4];
    logic [31:0] qa [4];
    logic [31:0] qb [4];
    logic [31:0] qc [4];
    logic [31:0] qd [4];

    for (genvar g = 0; g < 4; g++) begin : g_qr
        localparam int BC = 4 + g;
        localparam int CC = 8 + g;
        localparam int DC = 12 + g;
        localparam int BD = 4 + ((g + 1) % 4);
        localparam int CD = 8 + ((g + 2) % 4);
        localparam int DD = 12 + ((g + 3) % 4);

        assign ia[g] = state_i[g];
        assign ib[g] = diag_i ? state_i[BD] : state_i[BC];
        assign ic[g] = diag_i ? state_i[CD] : state_i[CC];
        assign id[g] = diag_i ? state_i[DD] : state_i[DC];

        quarter_round u_qr (
            .a_i (ia[g]),
            .b_i (ib[g]),
            .c_i (ic[g]),
            .d_i (id[g]),
            .a_o (qa[g]),
            .b_o (qb[g]),
            .c_o (qc[g]),
            .d_o (qd[g])
        );
    end

    // Write each result back to the word it was read from.
    always_comb begin
        state_o = state_i;
        for (int g = 0; g < 4; g++) begin
            state_o[g] = qa[g];
            if (diag_i) begin
                state_o[4  + ((g + 1) % 4)] = qb[g];
                state_o[8  + ((g + 2) % 4)] = qc[g];
                state_o[12 + ((g + 3) % 4)] = qd[g];
            end else begin
                state_o[4  + g] = qb[g];
                state_o[8  + g] = qc[g];
                state_o[12 + g] = qd[g];
            end
        end
    end

endmodule

// File: rtl/quarter_round.sv
// ChaCha quarter round, purely combinational.
//   a_i..d_i : input words
//   a_o..d_o : output words after the add/xor/rotate sequence (16,12,8,7)
module quarter_round
    import chacha_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic [31:0] d_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [31:0] c_o,
    output logic [31:0] d_o
);

    logic [31:0] a1, b1, c1, d1;
    logic [31:0] a2, b2, c2, d2;

    always_comb begin
        a1  = a_i + b_i;
        d1  = rotl32(d_i ^ a1, 16);
        c1  = c_i + d1;
        b1  = rotl32(b_i ^ c1, 12);
        a2  = a1 + b1;
        d2  = rotl32(d1 ^ a2, 8);
        c2  = c1 + d2;
        b2  = rotl32(b1 ^ c2, 7);
        a_o = a2;
        b_o = b2;
        c_o = c2;
        d_o = d2;
    end

endmodule

// File: rtl/chacha20_block.sv
// Sequential ChaCha20 block function: one half-round per cycle.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : request handshake carrying key, counter, nonce
//   key, counter, nonce : state words 4..11, 12, 13..15 (little-endian words)
//   ks_valid / ks_ready : keystream handshake
//   keystream           : 512-bit block, word i at [32*i +: 32]
//   busy                : high while rounds or the final add are in progress
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE and ks_valid only in DONE; both
// come straight from the state register, so there is no combinational path
// from in_valid or ks_ready to any output. in_valid outside IDLE and
// ks_ready outside DONE are ignored.
module chacha20_block
    import chacha_pkg::*;
#(
    parameter int ROUNDS = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] key,
    input  logic [31:0]  counter,
    input  logic [95:0]  nonce,
    output logic         ks_valid,
    input  logic         ks_ready,
    output logic [511:0] keystream,
    output logic         busy
);

    if (ROUNDS < 2 || (ROUNDS % 2) != 0) begin : g_bad_rounds
        $error("chacha20_block: ROUNDS must be even and >= 2");
    end

    localparam int RW = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;
    localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

    chacha_fsm_e   state_q, state_d;
    logic [RW-1:0] round_q, round_d;
    chacha_state_t init_q, init_d;
    chacha_state_t work_q, work_d;
    logic [511:0]  keystream_q, keystream_d;

    chacha_state_t in_state;
    chacha_state_t hr_state;
    chacha_state_t sum_state;

    always_comb unpack_state({nonce, counter, key, SIGMA}, in_state);

    // Even round index -> column round, odd -> diagonal round.
    chacha_half_round u_half_round (
        .state_i (work_q),
        .diag_i  (round_q[0]),
        .state_o (hr_state)
    );

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sum_state[i] = work_q[i] + init_q[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        init_d      = init_q;
        work_d      = work_q;
        keystream_d = keystream_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    init_d  = in_state;
                    work_d  = in_state;
                    round_d = '0;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                work_d  = hr_state;
                round_d = round_q + 1'b1;
                if (round_q == LAST_ROUND) begin
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                keystream_d = pack_state(sum_state);
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (ks_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            round_q     <= '0;
            init_q      <= '{default: '0};
            work_q      <= '{default: '0};
            keystream_q <= '0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            init_q      <= init_d;
            work_q      <= work_d;
            keystream_q <= keystream_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign ks_valid  = (state_q == ST_DONE);
    assign busy      = (state_q == ST_ROUND) || (state_q == ST_ADD);
    assign keystream = keystream_q;

endmodule

// File: doc/chacha20_block.md
Name: chacha20_block

Overview:
Sequential ChaCha20 block function (RFC 8439 §2.3) built on four existing quarter_round instances. Accepts key/nonce/counter via valid/ready, runs ROUNDS half-rounds at one per cycle (alternating column/diagonal), adds the initial state and presents a 512-bit keystream block via valid/ready. Sits between the cipher controller (upstream) and the XOR/output stage (downstream).

Parameters:
ROUNDS, 20, number of rounds (one half-round per cycle); must be even and ≥2; elaboration error otherwise.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  block idle, can accept
key  in  256  key; key[32*i+:32] = state word 4+i (little-endian words)
counter  in  32  block counter -> state word 12
nonce  in  96  nonce; nonce[32*i+:32] = state word 13+i
ks_valid  out  1  keystream block valid
ks_ready  in  1  downstream accepts keystream
keystream  out  512  keystream[32*i+:32] = output word i
busy  out  1  high in ROUND or ADD state

Behaviour:
- State words 0-3 fixed: 61707865, 3320646e, 79622d32, 6b206574.
- FSM: IDLE, ROUND, ADD, DONE. Reset -> IDLE; in_ready=1, ks_valid=0, busy=0, keystream=0, working/initial state registers=0, round counter=0.
- IDLE: in_ready=1. On in_valid&in_ready edge: latch initial state (16 words) into both init_reg and work_reg, round counter=0, -> ROUND. Inputs sampled only at that edge.
- ROUND: in_ready=0. Each cycle one half-round on work_reg: even count = column round QR(0,4,8,12) QR(1,5,9,13) QR(2,6,10,14) QR(3,7,11,15); odd count = diagonal QR(0,5,10,15) QR(1,6,11,12) QR(2,7,8,13) QR(3,4,9,14). Counter increments; after half-round index ROUNDS-1 -> ADD.
- ADD: keystream word i = work[i] + init[i] mod 2^32 (carry discarded), registered; -> DONE.
- DONE: ks_valid=1, keystream stable; in_ready=0. On ks_valid&ks_ready edge -> IDLE (ks_valid drops next cycle, keystream register retains value until next ADD).
- Latency: ks_valid rises ROUNDS+1 cycles after the accept edge (21 for default). Throughput one block per ROUNDS+3 cycles with ks_ready held high.
- in_valid while not IDLE: ignored, no effect on computation; upstream must hold it until in_ready.
- ks_ready while not DONE: ignored.
- Counter 0xffffffff used as-is; no increment or wrap handling inside this block (controller owns counter).
- rst asserted at any point (including mid-ROUND or DONE): outputs to reset values immediately, in-flight block discarded.
- No combinational path from in_valid/ks_ready to any output.

Decomposition:
- Package chacha_pkg: SIGMA constants (4 x 32-bit), typedef chacha_state_t (16 x 32-bit unpacked array), FSM state enum, pack/unpack functions between 512-bit vector and chacha_state_t.
- Sub-module chacha_half_round: combinational, inputs chacha_state_t + diagonal select bit, output chacha_state_t; wraps four quarter_round instances with the index muxing above. chacha20_block holds FSM, registers, adder.

Test Plan:
- RFC 8439 §2.3.2: key bytes 00..1f (word4=03020100 ... word11=1f1e1d1c), counter=1, nonce words 09000000, 4a000000, 00000000 -> keystream words 0..15 = e4e7f110 15593bd1 1fdd0f50 c47120a3 c7f4d1c7 0368c033 9aaa2204 4e6cd4c3 466482d2 09aa9f07 05d7c214 a2028bd9 d19c12b5 b94e16de e883d0cb 4e3c50a2; ks_valid exactly 21 cycles after accept edge.
- RFC 8439 A.1 #1: key=0, nonce=0, counter=0 -> word0=ade0b876, word1=903df1a0.
- Back-pressure: ks_ready=0 for 10 cycles after ks_valid -> ks_valid stays 1, keystream unchanged, in_ready=0; ks_ready=1 -> IDLE next cycle, in_ready=1.
- Busy-ignore: second in_valid with different key pulsed during ROUND -> first block's output unchanged (matches §2.3.2 vector); second request accepted only after DONE handshake.
- Back-to-back: in_valid and ks_ready tied high, two requests (counter=1, counter=2) -> two blocks 23 cycles apart, each matching software model.
- Mid-operation reset: assert rst at cycle 10 of ROUND -> in_ready=1, ks_valid=0, keystream=0 immediately; next request produces correct §2.3.2 result.
